// File: rtl/distance_text_ctl_pkg.sv
// distance_text_pkg: shared states, ASCII constants, line template and helpers for distance_text_ctl
package distance_text_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT_VBL,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int LINE_LEN   = 16;
    localparam int NUM_DIGITS = 5;

    localparam logic [6:0] SPACE  = 7'h20;
    localparam logic [6:0] COLON  = 7'h3A;
    localparam logic [6:0] DIGIT0 = 7'h30;

    // Index 0 is the leftmost character: "DIST: ddddd CM  "
    localparam logic [LINE_LEN-1:0][6:0] LABEL = {
        SPACE, SPACE, 7'h4D, 7'h43, SPACE,
        {NUM_DIGITS{DIGIT0}},
        SPACE, COLON, 7'h54, 7'h53, 7'h49, 7'h44
    };

    // Positions 6..10 carry the decimal digits, most significant first
    localparam logic [LINE_LEN-1:0] DIGIT_SLOT = 16'b0000_0111_1100_0000;
    localparam logic [3:0]          DIGIT_LAST = 4'd10;

    // One double-dabble correction: add 3 to every BCD nibble that is 5 or more
    function automatic logic [19:0] dd_adjust(input logic [19:0] b);
        logic [19:0] r;
        for (int k = 0; k < NUM_DIGITS; k++)
            r[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
        return r;
    endfunction

    // Character at position idx; hi holds this digit and all more significant ones
    function automatic logic [6:0] line_char(input logic [3:0] idx, input logic [19:0] bcd,
                                             input logic blank_lead);
        logic [5:0]  sh;
        logic [19:0] hi;
        sh = {DIGIT_LAST - idx, 2'b00};
        hi = bcd >> sh;
        if (!DIGIT_SLOT[idx])
            return LABEL[idx];
        return (blank_lead && idx != DIGIT_LAST && hi == '0) ? SPACE : DIGIT0 + {3'b000, hi[3:0]};
    endfunction

endpackage

// File: rtl/distance_text_ctl_if.sv
// distance_text_ctl_if: distance input, vblank and character-RAM write bundle
interface distance_text_ctl_if #(parameter int DIST_W = 16);

    logic [DIST_W-1:0] distance_in;
    logic              distance_valid;
    logic              vblnk_in;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [6:0]        wr_data;
    logic              busy;
    logic              done;

    modport master (
        output distance_in, distance_valid, vblnk_in,
        input  wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  distance_in, distance_valid, vblnk_in,
        output wr_en, wr_addr, wr_data, busy, done
    );

endinterface

// File: rtl/distance_text_ctl_bin2bcd_seq.sv
// bin2bcd_seq: serial double-dabble, one iteration per cycle for 16 cycles after start
module bin2bcd_seq
    import distance_text_pkg::*;
#(
    parameter int DIST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIST_W-1:0] bin_in,
    output logic [19:0]       bcd_out,
    output logic              ready
);

    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [19:0] adj;

    // ready flags the cycle whose closing edge performs the 16th iteration
    assign ready   = run_q && cnt_q == 4'hF;
    assign bcd_out = bcd_q;

    // Load on start, otherwise adjust-and-shift while running
    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        adj   = dd_adjust(bcd_q);
        if (start) begin
            bin_d              = '0;
            bin_d[DIST_W-1:0]  = bin_in;
            bcd_d              = '0;
            cnt_d              = '0;
            run_d              = 1'b1;
        end else if (run_q) begin
            bcd_d = {adj[18:0], bin_q[15]};
            bin_d = {bin_q[14:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            run_d = cnt_q != 4'hF;
        end
    end

    // Conversion state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/distance_text_ctl.sv
// distance_text_ctl: converts a distance reading to "DIST: ddddd CM  " and writes it during vblank
// Optional DIST_ZERO_BLANK_EN: leading zero digits are written as spaces
module distance_text_ctl
    import distance_text_pkg::*;
#(
    parameter int TEXT_ROW = 0,
    parameter int TEXT_COL = 0,
    parameter int DIST_W   = 16
) (
    input  logic                pclk,
    input  logic                rst,
    distance_text_ctl_if.slave  bus
);

`ifdef DIST_ZERO_BLANK_EN
    localparam logic BLANK = 1'b1;
`else
    localparam logic BLANK = 1'b0;
`endif

    localparam logic [2:0] ROW = TEXT_ROW[2:0];
    localparam logic [4:0] COL = TEXT_COL[4:0];

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              vbl_q;
    logic              pend_q, pend_d;
    logic [DIST_W-1:0] pval_q, pval_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [6:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              busy_q;
    logic              start;
    logic [DIST_W-1:0] start_val;
    logic [19:0]       bcd;
    logic              conv_last;

    bin2bcd_seq #(.DIST_W(DIST_W)) u_b2b (
        .clk    (pclk),
        .rst    (rst),
        .start  (start),
        .bin_in (start_val),
        .bcd_out(bcd),
        .ready  (conv_last)
    );

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // Sequencer next state, pending capture and the next write beat
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        pval_d    = pval_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        start     = 1'b0;
        start_val = bus.distance_in;
        if (bus.distance_valid && state_q != S_IDLE) begin
            pend_d = 1'b1;
            pval_d = bus.distance_in;
        end
        case (state_q)
            S_IDLE: begin
                // A pending value can reach IDLE when it was strobed in a DONE cycle
                if (bus.distance_valid || pend_q) begin
                    start     = 1'b1;
                    start_val = bus.distance_valid ? bus.distance_in : pval_q;
                    pend_d    = 1'b0;
                    state_d   = S_CONV;
                end
            end
            S_CONV: state_d = conv_last ? S_WAIT_VBL : S_CONV;
            S_WAIT_VBL: begin
                if (bus.vblnk_in && !vbl_q) begin
                    state_d = S_WRITE;
                    idx_d   = '0;
                    wr_en_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (idx_q == 4'(LINE_LEN - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    wr_en_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d   = pend_q ? S_CONV : S_IDLE;
                start     = pend_q;
                start_val = pval_q;
                if (pend_q)
                    pend_d = bus.distance_valid;
            end
            default: state_d = S_IDLE;
        endcase
        if (wr_en_d) begin
            wr_addr_d = {ROW, COL + {1'b0, idx_d}};
            wr_data_d = line_char(idx_d, bcd, BLANK);
        end
    end

    // State, vblank history and registered outputs
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            vbl_q     <= 1'b0;
            pend_q    <= 1'b0;
            pval_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vbl_q     <= bus.vblnk_in;
            pend_q    <= pend_d;
            pval_q    <= pval_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            busy_q    <= state_d != S_IDLE;
        end
    end

endmodule

// File: tb/tb_distance_text_ctl.sv
// tb_distance_text_ctl: random distance lines checked against a decimal-arithmetic line model
module tb_distance_text_ctl;

    localparam int ROW = 5;
    localparam int COL = 20;
    localparam int W   = 16;

`ifdef DIST_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 pclk = ~pclk;

    distance_text_ctl_if #(.DIST_W(W)) bus ();

    distance_text_ctl #(.TEXT_ROW(ROW), .TEXT_COL(COL), .DIST_W(W)) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Expected ASCII at position i of the line for distance v
    function automatic int exp_char(input int v, input int i);
        string s;
        int    p;
        s = "DIST: 00000 CM  ";
        if (i < 6 || i > 10)
            return int'(s[i]);
        p = 1;
        for (int k = 0; k < 10 - i; k++)
            p *= 10;
        if (BLANK && i < 10 && v < p)
            return 32;
        return 48 + (v / p) % 10;
    endfunction

    function automatic int exp_addr(input int i);
        return ROW * 32 + (COL + i) % 32;
    endfunction

    // Raise vblank now and check the whole burst, the done pulse and its latency
    task automatic expect_burst(input int v, input int drop_at, input bit ds_en, input int ds_val);
        int lat;
        lat = 0;
        bus.vblnk_in = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge pclk);
            if (bus.wr_en === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("first_write_latency", lat, 1);
        if (lat == 0)
            return;
        for (int i = 0; i < 16; i++) begin
            if (i > 0)
                @(negedge pclk);
            if (i == drop_at)
                bus.vblnk_in = 1'b0;
            chk($sformatf("wr_en[%0d]", i), bus.wr_en, 1);
            chk($sformatf("wr_addr[%0d]", i), bus.wr_addr, exp_addr(i));
            chk($sformatf("wr_data[%0d] v=%0d", i, v), bus.wr_data, exp_char(v, i));
            chk($sformatf("done_early[%0d]", i), bus.done, 0);
        end
        @(negedge pclk);
        chk("done_pulse", bus.done, 1);
        chk("wr_en_after_burst", bus.wr_en, 0);
        if (ds_en) begin
            bus.distance_in    = ds_val[15:0];
            bus.distance_valid = 1'b1;
        end
        bus.vblnk_in = 1'b0;
        @(negedge pclk);
        bus.distance_valid = 1'b0;
        chk("done_one_cycle", bus.done, 0);
    endtask

    initial begin
        int v, x, n_extra, drop_at, ds_val, writes, seen;
        bit pre_high, ds_en, pend_v;
        int pend_val;
        int fq[$];
        int vals[4];
        vals = '{123, 65535, 0, 100};
        bus.distance_in    = '0;
        bus.distance_valid = 1'b0;
        bus.vblnk_in       = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        @(negedge pclk);
        chk("idle_busy", bus.busy, 0);

        for (int it = 0; it < 14; it++) begin
            v        = (it < 4) ? vals[it] : int'($urandom_range(0, 65535));
            pre_high = (it == 2) || ($urandom_range(0, 3) == 0);
            n_extra  = (it == 3) ? 2 : ((it < 3) ? 0 : int'($urandom_range(0, 2)));
            ds_en    = (it >= 4) && ($urandom_range(0, 3) == 0);
            ds_val   = int'($urandom_range(0, 65535));
            drop_at  = int'($urandom_range(0, 24));
            pend_v   = 1'b0;
            pend_val = 0;
            writes   = 0;
            bus.distance_in    = v[15:0];
            bus.distance_valid = 1'b1;
            @(negedge pclk);
            bus.distance_valid = 1'b0;
            chk("busy_in_conv", bus.busy, 1);
            for (int c = 1; c <= 19; c++) begin
                bus.distance_valid = 1'b0;
                if ((c == 4 && n_extra > 0) || (c == 9 && n_extra > 1)) begin
                    x = (it == 3) ? ((c == 4) ? 200 : 300) : int'($urandom_range(0, 65535));
                    bus.distance_in    = x[15:0];
                    bus.distance_valid = 1'b1;
                    pend_v   = 1'b1;
                    pend_val = x;
                end
                if (c == 10 && pre_high)
                    bus.vblnk_in = 1'b1;
                @(negedge pclk);
                writes += int'(bus.wr_en);
            end
            bus.distance_valid = 1'b0;
            if (pre_high) begin
                repeat (10) begin
                    @(negedge pclk);
                    writes += int'(bus.wr_en);
                end
                bus.vblnk_in = 1'b0;
                @(negedge pclk);
                writes += int'(bus.wr_en);
            end
            chk("no_write_before_edge", writes, 0);
            expect_burst(v, drop_at, ds_en, ds_val);
            fq.delete();
            if (pend_v)
                fq.push_back(pend_val);
            if (ds_en)
                fq.push_back(ds_val);
            while (fq.size() > 0) begin
                x = fq.pop_front();
                writes = 0;
                repeat (22) begin
                    @(negedge pclk);
                    writes += int'(bus.wr_en);
                end
                chk("no_write_before_next_edge", writes, 0);
                expect_burst(x, 99, 1'b0, 0);
            end
            repeat (2) @(negedge pclk);
            chk("idle_after_lines", bus.busy, 0);
        end

        bus.distance_in    = 16'd77;
        bus.distance_valid = 1'b1;
        @(negedge pclk);
        bus.distance_valid = 1'b0;
        repeat (20) @(negedge pclk);
        bus.vblnk_in = 1'b1;
        seen = 0;
        for (int n = 0; n < 40 && seen < 8; n++) begin
            @(negedge pclk);
            seen += int'(bus.wr_en);
        end
        chk("reach_write_7", seen, 8);
        chk("data_at_7", bus.wr_data, exp_char(77, 7));
        rst = 1'b1;
        #1;
        chk("abort_wr_en", bus.wr_en, 0);
        chk("abort_wr_addr", bus.wr_addr, 0);
        chk("abort_wr_data", bus.wr_data, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        bus.vblnk_in = 1'b0;
        writes = 0;
        for (int n = 0; n < 40; n++) begin
            bus.vblnk_in = (n >= 10 && n < 25);
            @(negedge pclk);
            writes += int'(bus.wr_en) + int'(bus.done);
        end
        chk("no_write_after_reset", writes, 0);
        chk("idle_after_reset", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
